// File: rtl/bp_stall_counter_reader.sv
// bp_stall_counter_reader
//
// Takes a snapshot of a bank of live stall counters on request and streams it
// out over a valid/ready interface. Each stream is one header word followed by
// one word per counter, in index order:
//   header = {8'hA5, seq, els_p[15:0]}, zero-extended to width_p
// seq counts completed snapshots and wraps at 256. A request that arrives while
// a stream is in flight is dropped, and the sticky overrun flag records it.
//
// Ports
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   counters_i       live counters, counter k at [k*width_p +: width_p]
//   snap_req_i       snapshot request (accepted only while idle)
//   busy_o           a stream is in progress
//   data_o           stream word
//   v_o              data_o is valid
//   ready_and_i      consumer accepts data_o
//   done_o           one-cycle pulse after the last word is accepted
//   overrun_o        sticky: a request was dropped while busy
//   clear_overrun_i  clears overrun_o (a same-cycle set takes priority)
//   seq_o            number of completed snapshots, modulo 256

module bp_stall_counter_reader #(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 40
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p*width_p-1:0] counters_i,
  input  logic                     snap_req_i,
  output logic                     busy_o,
  output logic [width_p-1:0]       data_o,
  output logic                     v_o,
  input  logic                     ready_and_i,
  output logic                     done_o,
  output logic                     overrun_o,
  input  logic                     clear_overrun_i,
  output logic [7:0]               seq_o
);

  // A single-counter configuration still needs a 1-bit index.
  localparam int unsigned    IdxW     = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(els_p - 1);
  localparam logic [15:0]    ElsField = 16'(els_p);

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [7:0]         seq_q, seq_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic [width_p-1:0] snap_q [els_p];

  logic handshake;
  logic accept;
  logic last_word;

  // v_o depends on state only, so handshake never feeds back into v_o/data_o.
  assign handshake = v_o & ready_and_i;
  assign accept    = (state_q == StIdle) & snap_req_i;
  assign last_word = (state_q == StData) & handshake & (idx_q == LastIdx);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (snap_req_i) begin
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (handshake) begin
          state_d = StData;
        end
      end
      StData: begin
        if (handshake && (idx_q == LastIdx)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    busy_o = (state_q != StIdle);
    v_o    = (state_q != StIdle);
    data_o = '0;
    unique case (state_q)
      StIdle: data_o = '0;
      StHdr:  data_o = width_p'({8'hA5, seq_q, ElsField});
      StData: begin
        // Explicit mux keeps the read in range for non-power-of-two els_p.
        for (int k = 0; k < int'(els_p); k++) begin
          if (idx_q == IdxW'(k)) begin
            data_o = snap_q[k];
          end
        end
      end
      default: data_o = '0;
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath next state
  //--------------------------------------------------------------------------
  always_comb begin
    idx_d = idx_q;
    if ((state_q == StHdr) && handshake) begin
      idx_d = '0;
    end else if ((state_q == StData) && handshake && (idx_q != LastIdx)) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_comb begin
    seq_d  = last_word ? seq_q + 8'd1 : seq_q;
    done_d = last_word;
  end

  // Set has priority over clear so a dropped request is never lost.
  always_comb begin
    overrun_d = overrun_q;
    if (snap_req_i && busy_o) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q     <= '0;
      seq_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot is loaded only on the idle-accept edge; the stream reads from
  // here, so later changes on counters_i cannot leak into it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < int'(els_p); k++) begin
        snap_q[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < int'(els_p); k++) begin
        snap_q[k] <= counters_i[k*width_p +: width_p];
      end
    end
  end

  assign done_o    = done_q;
  assign overrun_o = overrun_q;
  assign seq_o     = seq_q;

  //--------------------------------------------------------------------------
  // Interface properties
  //--------------------------------------------------------------------------
  // Offered word holds until it is taken.
  a_stable_until_hs : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (v_o && !ready_and_i) |=> (v_o && $stable(data_o))
  );

  a_idx_in_range : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    idx_q <= LastIdx
  );

  a_done_single : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    done_o |=> !done_o
  );

  a_no_valid_idle : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (state_q == StIdle) |-> !v_o
  );

endmodule

// File: tb/tb_bp_stall_counter_reader.sv
module tb_bp_stall_counter_reader;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           reset_n_i = 1'b0;
  logic [N*W-1:0] counters_i = '0;
  logic           snap_req_i = 1'b0;
  logic           busy_o;
  logic [W-1:0]   data_o;
  logic           v_o;
  logic           ready_and_i = 1'b0;
  logic           done_o;
  logic           overrun_o;
  logic           clear_overrun_i = 1'b0;
  logic [7:0]     seq_o;

  bp_stall_counter_reader #(
    .width_p(W),
    .els_p  (N)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .counters_i     (counters_i),
    .snap_req_i     (snap_req_i),
    .busy_o         (busy_o),
    .data_o         (data_o),
    .v_o            (v_o),
    .ready_and_i    (ready_and_i),
    .done_o         (done_o),
    .overrun_o      (overrun_o),
    .clear_overrun_i(clear_overrun_i),
    .seq_o          (seq_o)
  );

  always #5 clk_i = ~clk_i;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a stream is just a queue of the words still owed to the consumer.
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  int          seq_m = 0;
  bit          ovr_m = 0;
  bit          done_m = 0;
  int          done_cnt = 0;
  bit          m_busy, m_fin;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      exp_q.delete();
      seq_m  = 0;
      ovr_m  = 0;
      done_m = 0;
    end else begin
      m_busy = (exp_q.size() != 0);
      m_fin  = 0;
      if (m_busy && ready_and_i) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_fin = 1;
          seq_m = (seq_m + 1) % 256;
        end
      end
      if (m_busy && snap_req_i) ovr_m = 1;
      else if (clear_overrun_i) ovr_m = 0;
      if (!m_busy && snap_req_i) begin
        exp_q.push_back({8'hA5, 8'(seq_m), 16'(N)});
        for (int k = 0; k < N; k++) exp_q.push_back(counters_i[k*W +: W]);
      end
      done_m = m_fin;
    end
  end

  // Compare every cycle, away from the active edge.
  logic [31:0] exp_data;
  always @(negedge clk_i) begin
    exp_data = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    check("v_o", 32'(v_o), 32'(exp_q.size() != 0));
    check("busy_o", 32'(busy_o), 32'(exp_q.size() != 0));
    check("data_o", data_o, exp_data);
    check("done_o", 32'(done_o), 32'(done_m));
    check("overrun_o", 32'(overrun_o), 32'(ovr_m));
    check("seq_o", 32'(seq_o), 32'(seq_m));
    if (v_o && ready_and_i) log_q.push_back(data_o);
    if (done_o) done_cnt++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done_o && n < bound) begin
      step();
      n++;
    end
    check("done_timeout", 32'(done_o), 32'd1);
  endtask

  task automatic check_stream(input string name, input logic [31:0] h, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d);
    check({name, "_len"}, 32'(log_q.size()), 32'd5);
    check({name, "_hdr"}, log_q[0], h);
    check({name, "_w0"}, log_q[1], a);
    check({name, "_w1"}, log_q[2], b);
    check({name, "_w2"}, log_q[3], c);
    check({name, "_w3"}, log_q[4], d);
  endtask

  int n;

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_v", 32'(v_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_seq", 32'(seq_o), 32'd0);
    reset_n_i = 1'b1;

    // Basic stream, request on the first edge after release
    counters_i  = {32'd40, 32'd30, 32'd20, 32'd10};
    ready_and_i = 1'b1;
    snap_req_i  = 1'b1;
    step();
    snap_req_i = 1'b0;
    wait_done(20, n);
    check("latency", 32'(n), 32'd5);
    step();
    check_stream("basic", 32'hA500_0004, 32'd10, 32'd20, 32'd30, 32'd40);
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    check("basic_seq", 32'(seq_o), 32'd1);

    // Snapshot isolation
    log_q.delete();
    counters_i = {32'd4, 32'd3, 32'd2, 32'd1};
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    n = 0;
    while (!done_o && n < 20) begin
      counters_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      n++;
    end
    check("iso_done", 32'(done_o), 32'd1);
    step();
    check_stream("iso", 32'hA501_0004, 32'd1, 32'd2, 32'd3, 32'd4);

    // Backpressure
    log_q.delete();
    counters_i  = {32'd400, 32'd300, 32'd200, 32'd100};
    snap_req_i  = 1'b1;
    ready_and_i = 1'($urandom_range(0, 1));
    step();
    snap_req_i = 1'b0;
    n = 0;
    while (!done_o && n < 200) begin
      ready_and_i = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("bp_done", 32'(done_o), 32'd1);
    ready_and_i = 1'b1;
    step();
    check_stream("bp", 32'hA502_0004, 32'd100, 32'd200, 32'd300, 32'd400);

    // Overrun during DATA
    log_q.delete();
    counters_i = {32'd8, 32'd7, 32'd6, 32'd5};
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    step();
    ready_and_i = 1'b0;
    counters_i  = {32'd99, 32'd99, 32'd99, 32'd99};
    snap_req_i  = 1'b1;
    step();
    snap_req_i = 1'b0;
    step();
    check("ovr_set", 32'(overrun_o), 32'd1);
    ready_and_i = 1'b1;
    wait_done(20, n);
    step();
    check_stream("ovr", 32'hA503_0004, 32'd5, 32'd6, 32'd7, 32'd8);
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;
    check("ovr_clr0", 32'(overrun_o), 32'd0);

    // Set and clear together during HDR: set wins
    log_q.delete();
    ready_and_i = 1'b0;
    snap_req_i  = 1'b1;
    step();
    clear_overrun_i = 1'b1;
    step();
    snap_req_i      = 1'b0;
    clear_overrun_i = 1'b0;
    check("ovr_setwins", 32'(overrun_o), 32'd1);
    clear_overrun_i = 1'b1;
    step();
    clear_overrun_i = 1'b0;
    check("ovr_clr1", 32'(overrun_o), 32'd0);
    ready_and_i = 1'b1;
    wait_done(20, n);
    step();
    check_stream("ovr2", 32'hA504_0004, 32'd99, 32'd99, 32'd99, 32'd99);

    // Reset mid-stream at idx=2, with overrun set
    counters_i = {32'd4, 32'd3, 32'd2, 32'd1};
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    step();
    snap_req_i = 1'b1;
    step();
    snap_req_i = 1'b0;
    step();
    check("pre_rst_seq", 32'(seq_o), 32'd5);
    check("pre_rst_ovr", 32'(overrun_o), 32'd1);
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_v", 32'(v_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_data", data_o, 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_ovr", 32'(overrun_o), 32'd0);
    check("mid_rst_seq", 32'(seq_o), 32'd0);
    step();
    step();
    reset_n_i = 1'b1;
    log_q.delete();
    done_cnt = 0;

    // Back-to-back, 256 snapshots then one more to show the wrap
    snap_req_i  = 1'b1;
    ready_and_i = 1'b1;
    n = 0;
    while (done_cnt < 256 && n < 2000) begin
      step();
      n++;
    end
    snap_req_i = 1'b0;
    check("wrap_count", 32'(done_cnt >= 256), 32'd1);
    wait_done(20, n);
    step();
    check("wrap_done_cnt", 32'(done_cnt), 32'd257);
    check("wrap_log_len", 32'(log_q.size()), 32'd1285);
    check("wrap_hdr0", log_q[0], 32'hA500_0004);
    check("wrap_w0", log_q[1], 32'd1);
    check("wrap_hdr255", log_q[5*255], 32'hA5FF_0004);
    check("wrap_hdr256", log_q[5*256], 32'hA500_0004);
    check("wrap_hdr1", log_q[5], 32'hA501_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
